// File: rtl/ram_sp_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_sp_rr_arbiter_pkg
// Shared constants, helper function and response-pipeline stage type for the
// round-robin single-port RAM arbiter.
// ---------------------------------------------------------------------------
package ram_sp_rr_arbiter_pkg;

    localparam int MAX_NUM_REQ = 8;

    // Requester index width; never narrower than one bit.
    function automatic int id_width(input int num_req);
        if (num_req <= 2) begin
            return 1;
        end
        return $clog2(num_req);
    endfunction

    localparam int MAX_ID_W = id_width(MAX_NUM_REQ);

    // The id field is sized for the largest supported requester count so a
    // single type serves every parameterisation; unused upper bits stay zero.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } rsp_stage_t;

endpackage

// File: rtl/ram_sp_rr_arbiter_rr_grant_sel.sv
// ---------------------------------------------------------------------------
// rr_grant_sel
// Combinational round-robin picker. Scans the request vector starting at the
// priority pointer, wrapping modulo NUM_REQ, and grants the first request.
//
// Ports
//   req_i        request vector, one bit per requester
//   ptr_i        index with highest priority this cycle (0..NUM_REQ-1)
//   gnt_o        one-hot grant (all zero when no request)
//   gnt_idx_o    index of the granted requester (0 when no request)
//   gnt_valid_o  any request granted
// ---------------------------------------------------------------------------
module rr_grant_sel #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    int k;

    // Walk offsets from farthest to nearest so the requester closest to the
    // pointer is the last writer and therefore wins.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        k           = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            k = int'(ptr_i) + j;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (req_i[k]) begin
                gnt_o       = '0;
                gnt_o[k]    = 1'b1;
                gnt_idx_o   = IDX_W'(k);
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_sp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ram_sp_rr_arbiter
// Shares one single-port write-first RAM among NUM_REQ requesters with a
// round-robin grant. Commands use valid/ready; responses are one-cycle pulses
// on o_rsp_valid[id] READ_LATENCY cycles after acceptance, with read data
// taken straight from the RAM output.
//
// Ports
//   i_clk, i_sync_rst        clock, synchronous active-high reset
//   i_req_valid/o_req_ready  per-requester command handshake
//   i_req_we/addr/wdata/byte_en  per-requester command fields (flattened)
//   o_rsp_valid, o_rsp_data  response pulse per requester, shared data
//   o_ram_*                  RAM port driven from the granted command
//   i_ram_rdata              RAM read data
//
// Build option
//   RAM_SP_RR_ARBITER_WR_RSP_EN  accepted writes also return a response
//                                (write acknowledge carrying the RAM echo).
// ---------------------------------------------------------------------------
module ram_sp_rr_arbiter
    import ram_sp_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int WORD_BIT_WIDTH = 32,
    parameter int DEPTH          = 256,
    parameter int READ_LATENCY   = 1
) (
    input  logic                                      i_clk,
    input  logic                                      i_sync_rst,
    input  logic [NUM_REQ-1:0]                        i_req_valid,
    output logic [NUM_REQ-1:0]                        o_req_ready,
    input  logic [NUM_REQ-1:0]                        i_req_we,
    input  logic [NUM_REQ*$clog2(DEPTH)-1:0]          i_req_addr,
    input  logic [NUM_REQ*WORD_BIT_WIDTH-1:0]         i_req_wdata,
    input  logic [NUM_REQ*(WORD_BIT_WIDTH/8)-1:0]     i_req_byte_en,
    output logic [NUM_REQ-1:0]                        o_rsp_valid,
    output logic [WORD_BIT_WIDTH-1:0]                 o_rsp_data,
    output logic                                      o_ram_we,
    output logic [$clog2(DEPTH)-1:0]                  o_ram_addr,
    output logic [WORD_BIT_WIDTH-1:0]                 o_ram_wdata,
    output logic [WORD_BIT_WIDTH/8-1:0]               o_ram_byte_en,
    input  logic [WORD_BIT_WIDTH-1:0]                 i_ram_rdata
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BE_W   = WORD_BIT_WIDTH / 8;
    localparam int ID_W   = id_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
        $error("ram_sp_rr_arbiter: NUM_REQ must be in 2..%0d", MAX_NUM_REQ);
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ram_sp_rr_arbiter: READ_LATENCY must be 1 or 2");
    end
    if (WORD_BIT_WIDTH < 8 || (WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0) begin : g_bad_width
        $error("ram_sp_rr_arbiter: WORD_BIT_WIDTH must be a power of 2 >= 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ram_sp_rr_arbiter: DEPTH must be a power of 2");
    end

    logic [ID_W-1:0]    prio_ptr_q;
    logic [ID_W-1:0]    prio_ptr_d;
    logic [NUM_REQ-1:0] req_eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_valid;
    rsp_stage_t         stage_d;
    rsp_stage_t         pipe_q [READ_LATENCY];
    rsp_stage_t         rsp_out;

    // Nothing is granted during reset, so no command is accepted and the RAM
    // sees no write.
    assign req_eligible = i_sync_rst ? '0 : i_req_valid;

    rr_grant_sel #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_grant_sel (
        .req_i       (req_eligible),
        .ptr_i       (prio_ptr_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign o_req_ready = gnt;

    always_comb begin
        o_ram_we      = 1'b0;
        o_ram_addr    = '0;
        o_ram_wdata   = '0;
        o_ram_byte_en = '0;
        if (gnt_valid) begin
            o_ram_we      = i_req_we[gnt_idx];
            o_ram_addr    = i_req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            o_ram_wdata   = i_req_wdata[int'(gnt_idx)*WORD_BIT_WIDTH +: WORD_BIT_WIDTH];
            o_ram_byte_en = i_req_byte_en[int'(gnt_idx)*BE_W +: BE_W];
        end
    end

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (gnt_valid) begin
            prio_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_comb begin
`ifdef RAM_SP_RR_ARBITER_WR_RSP_EN
        stage_d.valid = gnt_valid;
`else
        stage_d.valid = gnt_valid & ~o_ram_we;
`endif
        stage_d.id    = MAX_ID_W'(gnt_idx);
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            prio_ptr_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            prio_ptr_q <= prio_ptr_d;
            pipe_q[0]  <= stage_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // The last stage lines up with the RAM output register, so the data is
    // passed through unregistered and only qualified here.
    assign rsp_out = pipe_q[READ_LATENCY-1];

    always_comb begin
        o_rsp_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_rsp_valid[k] = rsp_out.valid && (rsp_out.id == MAX_ID_W'(k));
        end
    end

    assign o_rsp_data = rsp_out.valid ? i_ram_rdata : '0;

endmodule

// File: tb/tb_ram_sp_rr_arbiter.sv
// Bench: two arbiter instances (READ_LATENCY 1 and 2) share one stimulus
// stream, each backed by its own write-first RAM model. A behavioural model
// (memory array + expected-response queue) checks every cycle; a vector table
// carries hand-derived expectations for the directed scenarios.
module tb_ram_sp_rr_arbiter;

    localparam int N   = 2;
    localparam int W   = 32;
    localparam int D   = 256;
    localparam int AW  = 8;
    localparam int BEW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      vld;
    logic [N-1:0]      we;
    logic [N*AW-1:0]   addr;
    logic [N*W-1:0]    wdata;
    logic [N*BEW-1:0]  be;

    logic [N-1:0]      rdy_a      [2];
    logic [N-1:0]      rsp_v_a    [2];
    logic [W-1:0]      rsp_d_a    [2];
    logic              ram_we_a   [2];
    logic [AW-1:0]     ram_addr_a [2];
    logic [W-1:0]      ram_wd_a   [2];
    logic [BEW-1:0]    ram_be_a   [2];
    logic [W-1:0]      ram_rd_a   [2];

    for (genvar g = 0; g < 2; g++) begin : g_lat
        logic [W-1:0] mem [D];
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic [W-1:0] merged;

        ram_sp_rr_arbiter #(
            .NUM_REQ        (N),
            .WORD_BIT_WIDTH (W),
            .DEPTH          (D),
            .READ_LATENCY   (g + 1)
        ) u_dut (
            .i_clk         (clk),
            .i_sync_rst    (rst),
            .i_req_valid   (vld),
            .o_req_ready   (rdy_a[g]),
            .i_req_we      (we),
            .i_req_addr    (addr),
            .i_req_wdata   (wdata),
            .i_req_byte_en (be),
            .o_rsp_valid   (rsp_v_a[g]),
            .o_rsp_data    (rsp_d_a[g]),
            .o_ram_we      (ram_we_a[g]),
            .o_ram_addr    (ram_addr_a[g]),
            .o_ram_wdata   (ram_wd_a[g]),
            .o_ram_byte_en (ram_be_a[g]),
            .i_ram_rdata   (ram_rd_a[g])
        );

        initial begin
            for (int i = 0; i < D; i++) mem[i] = '0;
            rd1 = '0;
            rd2 = '0;
        end

        always_comb begin
            merged = mem[ram_addr_a[g]];
            for (int b = 0; b < BEW; b++) begin
                if (ram_be_a[g][b]) merged[b*8 +: 8] = ram_wd_a[g][b*8 +: 8];
            end
        end

        always @(posedge clk) begin
            if (ram_we_a[g]) mem[ram_addr_a[g]] <= merged;
            rd1 <= ram_we_a[g] ? merged : mem[ram_addr_a[g]];
            rd2 <= rd1;
        end

        assign ram_rd_a[g] = (g == 0) ? rd1 : rd2;
    end

    // ---------------- reference model state ----------------
    typedef struct {
        int           due;
        int           lat;
        int           id;
        logic [W-1:0] data;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] mmem [D];
    int           ptr;
    int           cyc;
    int           n_asserts;
    int           n_fail;
    bit           wr_rsp;

    typedef struct {
        logic           rst;
        logic [1:0]     vld;
        logic [1:0]     we;
        logic [AW-1:0]  a0, a1;
        logic [W-1:0]   d0, d1;
        logic [BEW-1:0] be0, be1;
        logic [1:0]     rdy;
        logic [1:0]     v1;
        logic [W-1:0]   x1;
        logic [1:0]     v2;
        logic [W-1:0]   x2;
    } vec_t;

    localparam int NT = 31;
    vec_t tab [NT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_asserts++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual %h required %h", name, cyc, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        rst   = v.rst;
        vld   = v.vld;
        we    = v.we;
        addr  = {v.a1, v.a0};
        wdata = {v.d1, v.d0};
        be    = {v.be1, v.be0};
    endtask

    // One clock cycle: model checks at the falling edge, optional table
    // checks, model update for the coming rising edge.
    task automatic run_cycle(input bit has_tab, input vec_t v,
                             output logic [N-1:0] acc, output logic [N-1:0] rdy_seen);
        int           g;
        int           k;
        int           a;
        logic [N-1:0] er;
        logic [44:0]  eport;
        logic [N-1:0] ev;
        logic [W-1:0] ed;
        logic [W-1:0] nw;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int j = 0; j < N; j++) begin
                k = (ptr + j) % N;
                if (g < 0 && vld[k]) g = k;
            end
        end
        er    = '0;
        eport = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            eport = {we[g], addr[g*AW +: AW], wdata[g*W +: W], be[g*BEW +: BEW]};
        end
        for (int l = 0; l < 2; l++) begin
            chk("ready", 64'(rdy_a[l]), 64'(er));
            chk("ram_port", 64'({ram_we_a[l], ram_addr_a[l], ram_wd_a[l], ram_be_a[l]}), 64'(eport));
            ev = '0;
            ed = '0;
            foreach (expq[i]) begin
                if (expq[i].lat == l && expq[i].due == cyc) begin
                    ev[expq[i].id] = 1'b1;
                    ed = expq[i].data;
                end
            end
            chk("rsp", 64'({rsp_v_a[l], rsp_d_a[l]}), 64'({ev, ed}));
        end
        if (has_tab) begin
            chk("tab_ready", 64'(rdy_a[1]), 64'(v.rdy));
`ifndef RAM_SP_RR_ARBITER_WR_RSP_EN
            chk("tab_rsp_lat1", 64'({rsp_v_a[0], rsp_d_a[0]}), 64'({v.v1, v.x1}));
            chk("tab_rsp_lat2", 64'({rsp_v_a[1], rsp_d_a[1]}), 64'({v.v2, v.x2}));
`endif
        end
        rdy_seen = rdy_a[1];
        acc      = er;
        while (expq.size() > 0 && expq[0].due <= cyc) void'(expq.pop_front());
        if (rst) begin
            expq.delete();
            ptr = 0;
        end else if (g >= 0) begin
            ptr = (g + 1) % N;
            a   = int'(addr[g*AW +: AW]);
            if (we[g]) begin
                nw = mmem[a];
                for (int b = 0; b < BEW; b++) begin
                    if (be[g*BEW + b]) nw[b*8 +: 8] = wdata[g*W + b*8 +: 8];
                end
                mmem[a] = nw;
            end
            if (!we[g] || wr_rsp) begin
                for (int l = 0; l < 2; l++) expq.push_back('{cyc + l + 1, l, g, mmem[a]});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t         nv;
        logic [N-1:0] acc;
        logic [N-1:0] rs;
        int           wait_cnt [N];
        int           max_wait;

`ifdef RAM_SP_RR_ARBITER_WR_RSP_EN
        wr_rsp = 1'b1;
`else
        wr_rsp = 1'b0;
`endif
        n_asserts = 0;
        n_fail    = 0;
        cyc       = 0;
        ptr       = 0;
        for (int i = 0; i < D; i++) mmem[i] = '0;
        nv = '{default: '0};

        //            rst vld   we    a0 a1  d0            d1            be0   be1    rdy   v1    x1            v2    x2
        tab[0]  = '{1, 2'b11, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b00, 0,            2'b00, 0};
        tab[1]  = '{0, 2'b01, 2'b01, 5, 0, 32'hDEADBEEF, 0,            4'hF, 0,    2'b01, 2'b00, 0,            2'b00, 0};
        tab[2]  = '{0, 2'b10, 2'b10, 0, 9, 0,            32'hAABBCCDD, 0,    4'hF, 2'b10, 2'b00, 0,            2'b00, 0};
        tab[3]  = '{0, 2'b01, 2'b01, 1, 0, 32'h00000111, 0,            4'hF, 0,    2'b01, 2'b00, 0,            2'b00, 0};
        tab[4]  = '{0, 2'b10, 2'b10, 0, 2, 0,            32'h00000222, 0,    4'hF, 2'b10, 2'b00, 0,            2'b00, 0};
        tab[5]  = '{0, 2'b01, 2'b00, 5, 0, 0,            0,            0,    0,    2'b01, 2'b00, 0,            2'b00, 0};
        tab[6]  = '{0, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b01, 32'hDEADBEEF, 2'b00, 0};
        tab[7]  = '{0, 2'b10, 2'b00, 0, 2, 0,            0,            0,    0,    2'b10, 2'b00, 0,            2'b01, 32'hDEADBEEF};
        tab[8]  = '{0, 2'b11, 2'b00, 1, 2, 0,            0,            0,    0,    2'b01, 2'b10, 32'h222,      2'b00, 0};
        tab[9]  = '{0, 2'b11, 2'b00, 1, 2, 0,            0,            0,    0,    2'b10, 2'b01, 32'h111,      2'b10, 32'h222};
        tab[10] = '{0, 2'b11, 2'b00, 1, 2, 0,            0,            0,    0,    2'b01, 2'b10, 32'h222,      2'b01, 32'h111};
        tab[11] = '{0, 2'b11, 2'b00, 1, 2, 0,            0,            0,    0,    2'b10, 2'b01, 32'h111,      2'b10, 32'h222};
        tab[12] = '{0, 2'b11, 2'b00, 1, 2, 0,            0,            0,    0,    2'b01, 2'b10, 32'h222,      2'b01, 32'h111};
        tab[13] = '{0, 2'b11, 2'b00, 1, 2, 0,            0,            0,    0,    2'b10, 2'b01, 32'h111,      2'b10, 32'h222};
        tab[14] = '{0, 2'b10, 2'b10, 0, 9, 0,            32'h11223344, 0,    4'h3, 2'b10, 2'b10, 32'h222,      2'b01, 32'h111};
        tab[15] = '{0, 2'b01, 2'b00, 9, 0, 0,            0,            0,    0,    2'b01, 2'b00, 0,            2'b10, 32'h222};
        tab[16] = '{0, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b01, 32'hAABB3344, 2'b00, 0};
        tab[17] = '{0, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b00, 0,            2'b01, 32'hAABB3344};
        tab[18] = '{0, 2'b10, 2'b00, 0, 5, 0,            0,            0,    0,    2'b10, 2'b00, 0,            2'b00, 0};
        tab[19] = '{0, 2'b10, 2'b00, 0, 1, 0,            0,            0,    0,    2'b10, 2'b10, 32'hDEADBEEF, 2'b00, 0};
        tab[20] = '{0, 2'b10, 2'b00, 0, 2, 0,            0,            0,    0,    2'b10, 2'b10, 32'h111,      2'b10, 32'hDEADBEEF};
        tab[21] = '{0, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b10, 32'h222,      2'b10, 32'h111};
        tab[22] = '{0, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b00, 0,            2'b10, 32'h222};
        tab[23] = '{0, 2'b01, 2'b00, 5, 0, 0,            0,            0,    0,    2'b01, 2'b00, 0,            2'b00, 0};
        tab[24] = '{1, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b01, 32'hDEADBEEF, 2'b00, 0};
        tab[25] = '{0, 2'b11, 2'b00, 1, 2, 0,            0,            0,    0,    2'b01, 2'b00, 0,            2'b00, 0};
        tab[26] = '{0, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b01, 32'h111,      2'b00, 0};
        tab[27] = '{0, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b00, 0,            2'b01, 32'h111};
        tab[28] = '{0, 2'b01, 2'b01, 3, 0, 32'h5A5A5A5A, 0,            4'hF, 0,    2'b01, 2'b00, 0,            2'b00, 0};
        tab[29] = '{0, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b00, 0,            2'b00, 0};
        tab[30] = '{0, 2'b00, 2'b00, 0, 0, 0,            0,            0,    0,    2'b00, 2'b00, 0,            2'b00, 0};

        rst = 1'b1; vld = '0; we = '0; addr = '0; wdata = '0; be = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) run_cycle(1'b0, nv, acc, rs);

        for (int i = 0; i < NT; i++) begin
            apply(tab[i]);
            run_cycle(1'b1, tab[i], acc, rs);
        end

        // Fairness after reset: both requesters read continuously, grant
        // must start at requester 0 and alternate.
        rst = 1'b1; vld = '0;
        run_cycle(1'b0, nv, acc, rs);
        rst = 1'b0; vld = 2'b11; we = 2'b00; addr = {8'd2, 8'd1};
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, nv, acc, rs);
            chk("fair_rotation", 64'(rs), 64'(1 << (i % 2)));
        end
        vld = '0;
        for (int i = 0; i < 3; i++) run_cycle(1'b0, nv, acc, rs);

        // Randomised traffic; each requester holds its command until accepted.
        max_wait = 0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (vld[k] && acc[k]) vld[k] = 1'b0;
                if (!vld[k] && $urandom_range(0, 99) < 70) begin
                    vld[k]             = 1'b1;
                    we[k]              = 1'($urandom_range(0, 1));
                    addr[k*AW +: AW]   = AW'($urandom_range(0, 15));
                    wdata[k*W +: W]    = $urandom;
                    be[k*BEW +: BEW]   = BEW'($urandom_range(0, 15));
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            run_cycle(1'b0, nv, acc, rs);
            for (int k = 0; k < N; k++) begin
                if (rst || !vld[k] || rs[k]) wait_cnt[k] = 0;
                else wait_cnt[k]++;
                if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
            end
        end
        chk("max_wait_within_bound", 64'(max_wait <= N - 1), 64'd1);

        rst = 1'b0; vld = '0;
        for (int i = 0; i < 3; i++) run_cycle(1'b0, nv, acc, rs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
